flags_ctrl: RTL and testbench

- Sequencing controller for the C/Z flag register block (FLAGS): turns per-instruction flag operations and interrupt entry/exit events into the FLAGS control strobes (FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD).
- Owns the interrupt-enable flag I_FLG and the shadow save/restore sequence.
- Sits between the control unit (instruction decode) and FLAGS; FLAGS itself is unchanged.

---
 rtl/flags_ctrl_pkg.sv | 36 +++
 rtl/flags_ctrl_if.sv | 31 +++
 rtl/flags_ctrl_op_decode.sv | 25 ++
 rtl/flags_ctrl.sv | 113 +++++++++++
 tb/tb_flags_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flags_ctrl_pkg.sv
// Shared types for the FLAGS sequencing controller: op codes, FSM states, strobe bundle.
package flags_ctrl_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    LD_CZ = 4'd1,
    LD_Z  = 4'd2,
    LD_C  = 4'd3,
    SET_C = 4'd4,
    CLR_C = 4'd5,
    SEI   = 4'd6,
    CLI   = 4'd7,
    RETID = 4'd8,
    RETIE = 4'd9
  } flg_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INT_SAVE = 3'd1,
    INT_CLR  = 3'd2,
    INT_ACK  = 3'd3,
    RESTORE  = 3'd4
  } fsm_state_t;

  typedef struct packed {
    logic c_set;
    logic c_clr;
    logic c_ld;
    logic z_ld;
    logic ld_sel;
    logic shad_ld;
  } flg_strobes_t;

  localparam flg_strobes_t STROBES_NONE = '0;

endpackage

// File: rtl/flags_ctrl_if.sv
// Bundle between the control unit (master) and the flags sequencing controller (slave).
interface flags_ctrl_if;
  import flags_ctrl_pkg::*;

  logic    INSTR_VALID;
  flg_op_t FLG_OP;
  logic    INTR;
  logic    FLG_C_SET;
  logic    FLG_C_CLR;
  logic    FLG_C_LD;
  logic    FLG_Z_LD;
  logic    FLG_LD_SEL;
  logic    FLG_SHAD_LD;
  logic    I_FLG;
  logic    INTR_ACK;
  logic    BUSY;
  logic    PROTO_ERR;

  modport master (
    output INSTR_VALID, FLG_OP, INTR,
    input  FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
    input  I_FLG, INTR_ACK, BUSY, PROTO_ERR
  );

  modport slave (
    input  INSTR_VALID, FLG_OP, INTR,
    output FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
    output I_FLG, INTR_ACK, BUSY, PROTO_ERR
  );

endinterface

// File: rtl/flags_ctrl_op_decode.sv
// Combinational decode of a flag op code into FLAGS strobes (I-flag and return ops raise none).
module flags_op_decode
  import flags_ctrl_pkg::*;
(
  input  flg_op_t      op,
  output flg_strobes_t strb
);

  // Map each op to its strobe set; unassigned codes behave as NOP.
  always_comb begin
    strb = STROBES_NONE;
    case (op)
      LD_CZ: begin
        strb.c_ld = 1'b1;
        strb.z_ld = 1'b1;
      end
      LD_Z:    strb.z_ld  = 1'b1;
      LD_C:    strb.c_ld  = 1'b1;
      SET_C:   strb.c_set = 1'b1;
      CLR_C:   strb.c_clr = 1'b1;
      default: strb = STROBES_NONE;
    endcase
  end

endmodule

// File: rtl/flags_ctrl.sv
// Flags sequencing controller: per-instruction strobes, interrupt save/ack, and return restore.
module flags_ctrl
  import flags_ctrl_pkg::*;
#(
  parameter bit          INT_CLR_C  = 1'b1,
  parameter int unsigned ACK_CYCLES = 1
) (
  input logic         CLK,
  input logic         RST_N,
  flags_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_INT_SAVE = INT_SAVE;
  localparam logic [2:0] ST_INT_CLR  = INT_CLR;
  localparam logic [2:0] ST_INT_ACK  = INT_ACK;
  localparam logic [2:0] ST_RESTORE  = RESTORE;

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [3:0]   ack_cnt;
  logic         i_flg;
  logic         proto_err;
  logic         op_take;
  logic         op_ret;
  flg_strobes_t dec_strb;
  flg_strobes_t strb;

  flags_op_decode u_decode (
    .op   (bus.FLG_OP),
    .strb (dec_strb)
  );

  // An op is only honoured in IDLE; anything offered while busy is dropped.
  assign op_take = bus.INSTR_VALID && (state == ST_IDLE);
  assign op_ret  = op_take && ((bus.FLG_OP == RETID) || (bus.FLG_OP == RETIE));

  // Strobes: decoder output in IDLE, fixed sequence strobes elsewhere.
  always_comb begin
    strb = STROBES_NONE;
    case (state)
      ST_IDLE:     if (bus.INSTR_VALID) strb = dec_strb;
      ST_INT_SAVE: strb.shad_ld = 1'b1;
      ST_INT_CLR:  strb.c_clr = INT_CLR_C;
      ST_RESTORE: begin
        strb.ld_sel = 1'b1;
        strb.c_ld   = 1'b1;
        strb.z_ld   = 1'b1;
      end
      default:     strb = STROBES_NONE;
    endcase
  end

  // Next state: a return op outranks interrupt acceptance; acceptance uses registered I_FLG.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (op_ret)                    state_nxt = ST_RESTORE;
        else if (bus.INTR && i_flg)    state_nxt = ST_INT_SAVE;
      end
      ST_INT_SAVE: state_nxt = ST_INT_CLR;
      ST_INT_CLR:  state_nxt = ST_INT_ACK;
      ST_INT_ACK:  if (ack_cnt == 4'd0) state_nxt = ST_IDLE;
      ST_RESTORE:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: state, ack countdown, interrupt enable, sticky protocol error.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      ack_cnt   <= 4'd0;
      i_flg     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_INT_CLR)
        ack_cnt <= 4'(ACK_CYCLES - 1);
      else if ((state == ST_INT_ACK) && (ack_cnt != 4'd0))
        ack_cnt <= ack_cnt - 4'd1;

      if (op_take) begin
        case (bus.FLG_OP)
          SEI:     i_flg <= 1'b1;
          CLI:     i_flg <= 1'b0;
          RETID:   i_flg <= 1'b0;
          RETIE:   i_flg <= 1'b1;
          default: i_flg <= i_flg;
        endcase
      end else if (state == ST_INT_SAVE) begin
        i_flg <= 1'b0;
      end

      if (bus.INSTR_VALID && (state != ST_IDLE))
        proto_err <= 1'b1;
    end
  end

  assign bus.FLG_C_SET   = strb.c_set;
  assign bus.FLG_C_CLR   = strb.c_clr;
  assign bus.FLG_C_LD    = strb.c_ld;
  assign bus.FLG_Z_LD    = strb.z_ld;
  assign bus.FLG_LD_SEL  = strb.ld_sel;
  assign bus.FLG_SHAD_LD = strb.shad_ld;
  assign bus.I_FLG       = i_flg;
  assign bus.INTR_ACK    = (state == ST_INT_ACK);
  assign bus.BUSY        = (state != ST_IDLE);
  assign bus.PROTO_ERR   = proto_err;

endmodule

// File: tb/tb_flags_ctrl.sv
// Directed bench for flags_ctrl: one DUT with ACK_CYCLES=1 driving a FLAGS model, one with ACK_CYCLES=4.
module tb_flags_ctrl;
  import flags_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  flags_ctrl_if ifa ();
  flags_ctrl_if ifb ();

  flags_ctrl #(.INT_CLR_C(1'b1), .ACK_CYCLES(1)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifa.slave)
  );

  flags_ctrl #(.INT_CLR_C(1'b1), .ACK_CYCLES(4)) dut4 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifb.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic alu_c, alu_z;
  logic c_flg, z_flg, sh_c, sh_z;

  wire [5:0] strb_a = {ifa.FLG_C_SET, ifa.FLG_C_CLR, ifa.FLG_C_LD,
                       ifa.FLG_Z_LD, ifa.FLG_LD_SEL, ifa.FLG_SHAD_LD};
  wire [5:0] strb_b = {ifb.FLG_C_SET, ifb.FLG_C_CLR, ifb.FLG_C_LD,
                       ifb.FLG_Z_LD, ifb.FLG_LD_SEL, ifb.FLG_SHAD_LD};

  // Behavioural FLAGS block driven by the first DUT's strobes.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_flg <= 1'b0; z_flg <= 1'b0; sh_c <= 1'b0; sh_z <= 1'b0;
    end else begin
      if (ifa.FLG_SHAD_LD) begin sh_c <= c_flg; sh_z <= z_flg; end
      if (ifa.FLG_C_SET)      c_flg <= 1'b1;
      else if (ifa.FLG_C_CLR) c_flg <= 1'b0;
      else if (ifa.FLG_C_LD)  c_flg <= ifa.FLG_LD_SEL ? sh_c : alu_c;
      if (ifa.FLG_Z_LD)       z_flg <= ifa.FLG_LD_SEL ? sh_z : alu_z;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP; ifa.INTR = 1'b0;
    ifb.INSTR_VALID = 1'b0; ifb.FLG_OP = NOP; ifb.INTR = 1'b0;
    alu_c = 1'b0; alu_z = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_run++;
    if ({strb_a, strb_b} !== 12'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b exp %b", {strb_a, strb_b}, 12'b0);
    end
    n_run++;
    if ({ifa.I_FLG, ifa.BUSY, ifa.INTR_ACK, ifa.PROTO_ERR,
         ifb.I_FLG, ifb.BUSY, ifb.INTR_ACK, ifb.PROTO_ERR} !== 8'b0) begin
      n_fail++; $display("FAIL reset_status got %b exp %b",
        {ifa.I_FLG, ifa.BUSY, ifa.INTR_ACK, ifa.PROTO_ERR,
         ifb.I_FLG, ifb.BUSY, ifb.INTR_ACK, ifb.PROTO_ERR}, 8'b0);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_ld_cz;
    alu_c = 1'b1; alu_z = 1'b1;
    ifa.INSTR_VALID = 1'b1; ifa.FLG_OP = LD_CZ;
    #1;
    n_run++;
    if (strb_a !== 6'b001100) begin
      n_fail++; $display("FAIL ldcz_strobes got %b exp %b", strb_a, 6'b001100);
    end
    tick();
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP;
    #1;
    n_run++;
    if (strb_a !== 6'b000000) begin
      n_fail++; $display("FAIL ldcz_one_cycle got %b exp %b", strb_a, 6'b000000);
    end
    n_run++;
    if ({c_flg, z_flg} !== 2'b11) begin
      n_fail++; $display("FAIL ldcz_flags got %b exp %b", {c_flg, z_flg}, 2'b11);
    end
  endtask

  task automatic test_interrupt;
    ifa.INSTR_VALID = 1'b1; ifa.FLG_OP = SEI;
    tick();
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP;
    ifa.INTR = 1'b1;
    #1;
    n_run++;
    if ({ifa.I_FLG, ifa.BUSY} !== 2'b10) begin
      n_fail++; $display("FAIL sei_then_idle got %b exp %b", {ifa.I_FLG, ifa.BUSY}, 2'b10);
    end
    tick();  // accepting edge -> INT_SAVE
    n_run++;
    if ({strb_a, ifa.BUSY, ifa.INTR_ACK, ifa.I_FLG} !== 9'b000001_1_0_1) begin
      n_fail++; $display("FAIL int_save got %b exp %b",
        {strb_a, ifa.BUSY, ifa.INTR_ACK, ifa.I_FLG}, 9'b000001_1_0_1);
    end
    tick();  // INT_CLR
    n_run++;
    if ({strb_a, ifa.BUSY, ifa.INTR_ACK, ifa.I_FLG} !== 9'b010000_1_0_0) begin
      n_fail++; $display("FAIL int_clr got %b exp %b",
        {strb_a, ifa.BUSY, ifa.INTR_ACK, ifa.I_FLG}, 9'b010000_1_0_0);
    end
    tick();  // INT_ACK, third cycle after acceptance
    n_run++;
    if ({strb_a, ifa.BUSY, ifa.INTR_ACK} !== 8'b000000_1_1) begin
      n_fail++; $display("FAIL int_ack got %b exp %b",
        {strb_a, ifa.BUSY, ifa.INTR_ACK}, 8'b000000_1_1);
    end
    tick();  // back to IDLE, INTR still high but I_FLG is 0
    n_run++;
    if ({ifa.BUSY, ifa.INTR_ACK} !== 2'b00) begin
      n_fail++; $display("FAIL int_done got %b exp %b", {ifa.BUSY, ifa.INTR_ACK}, 2'b00);
    end
    n_run++;
    if ({c_flg, z_flg, sh_c, sh_z} !== 4'b0111) begin
      n_fail++; $display("FAIL int_flags got %b exp %b", {c_flg, z_flg, sh_c, sh_z}, 4'b0111);
    end
    ifa.INTR = 1'b0;
  endtask

  task automatic test_retie;
    alu_z = 1'b0;
    ifa.INSTR_VALID = 1'b1; ifa.FLG_OP = LD_Z;
    tick();
    ifa.FLG_OP = RETIE;
    #1;
    n_run++;
    if ({strb_a, z_flg} !== 7'b000000_0) begin
      n_fail++; $display("FAIL retie_issue got %b exp %b", {strb_a, z_flg}, 7'b000000_0);
    end
    tick();  // RESTORE
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP;
    #1;
    n_run++;
    if ({strb_a, ifa.BUSY, ifa.I_FLG} !== 8'b001110_1_1) begin
      n_fail++; $display("FAIL restore got %b exp %b", {strb_a, ifa.BUSY, ifa.I_FLG}, 8'b001110_1_1);
    end
    tick();
    n_run++;
    if ({c_flg, z_flg, ifa.BUSY, ifa.I_FLG} !== 4'b1101) begin
      n_fail++; $display("FAIL restore_done got %b exp %b", {c_flg, z_flg, ifa.BUSY, ifa.I_FLG}, 4'b1101);
    end
  endtask

  task automatic test_same_cycle;
    alu_c = 1'b0;
    ifa.INSTR_VALID = 1'b1; ifa.FLG_OP = LD_C; ifa.INTR = 1'b1;
    #1;
    n_run++;
    if (strb_a !== 6'b001000) begin
      n_fail++; $display("FAIL same_ldc got %b exp %b", strb_a, 6'b001000);
    end
    tick();  // INT_SAVE
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP;
    #1;
    n_run++;
    if ({strb_a, c_flg} !== 7'b000001_0) begin
      n_fail++; $display("FAIL same_save got %b exp %b", {strb_a, c_flg}, 7'b000001_0);
    end
    tick();  // INT_CLR
    n_run++;
    if (sh_c !== 1'b0) begin
      n_fail++; $display("FAIL same_shadow_c got %b exp %b", sh_c, 1'b0);
    end
  endtask

  task automatic test_proto_err;
    // Still in INT_CLR from the previous scenario.
    ifa.INSTR_VALID = 1'b1; ifa.FLG_OP = SET_C;
    #1;
    n_run++;
    if ({strb_a, ifa.PROTO_ERR} !== 7'b010000_0) begin
      n_fail++; $display("FAIL busy_setc got %b exp %b", {strb_a, ifa.PROTO_ERR}, 7'b010000_0);
    end
    tick();  // INT_ACK
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP; ifa.INTR = 1'b0;
    #1;
    n_run++;
    if ({ifa.PROTO_ERR, ifa.INTR_ACK} !== 2'b11) begin
      n_fail++; $display("FAIL proto_set got %b exp %b", {ifa.PROTO_ERR, ifa.INTR_ACK}, 2'b11);
    end
    tick();  // IDLE
    ifa.INSTR_VALID = 1'b1; ifa.FLG_OP = RETID;
    tick();  // RESTORE
    ifa.INSTR_VALID = 1'b0; ifa.FLG_OP = NOP;
    #1;
    n_run++;
    if ({strb_a, ifa.I_FLG, ifa.PROTO_ERR} !== 8'b001110_0_1) begin
      n_fail++; $display("FAIL retid got %b exp %b", {strb_a, ifa.I_FLG, ifa.PROTO_ERR}, 8'b001110_0_1);
    end
    tick();
    n_run++;
    if ({c_flg, ifa.BUSY, ifa.PROTO_ERR} !== 3'b001) begin
      n_fail++; $display("FAIL proto_sticky got %b exp %b", {c_flg, ifa.BUSY, ifa.PROTO_ERR}, 3'b001);
    end
  endtask

  task automatic test_ack4_reset;
    int first;
    int n_ack;
    first = -1;
    n_ack = 0;
    ifb.INSTR_VALID = 1'b1; ifb.FLG_OP = SEI;
    tick();
    ifb.INSTR_VALID = 1'b0; ifb.FLG_OP = NOP; ifb.INTR = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ifb.INTR_ACK) begin
        n_ack++;
        if (first < 0) first = i;
      end
    end
    n_run++;
    if ({first, n_ack} !== {32'sd3, 32'sd4}) begin
      n_fail++; $display("FAIL ack4_timing got first=%0d n=%0d exp first=3 n=4", first, n_ack);
    end
    n_run++;
    if ({ifb.BUSY, ifb.I_FLG} !== 2'b00) begin
      n_fail++; $display("FAIL ack4_done got %b exp %b", {ifb.BUSY, ifb.I_FLG}, 2'b00);
    end
    // SEI with INTR already high: acceptance waits one cycle for the registered I_FLG.
    ifb.INSTR_VALID = 1'b1; ifb.FLG_OP = SEI;
    tick();
    ifb.INSTR_VALID = 1'b0; ifb.FLG_OP = NOP;
    #1;
    n_run++;
    if ({ifb.BUSY, ifb.I_FLG} !== 2'b01) begin
      n_fail++; $display("FAIL sei_delay got %b exp %b", {ifb.BUSY, ifb.I_FLG}, 2'b01);
    end
    tick(); tick(); tick(); tick();  // SAVE, CLR, ACK1, ACK2
    n_run++;
    if ({ifb.INTR_ACK, ifb.BUSY} !== 2'b11) begin
      n_fail++; $display("FAIL ack4_mid got %b exp %b", {ifb.INTR_ACK, ifb.BUSY}, 2'b11);
    end
    #2 RST_N = 1'b0;
    #1;
    n_run++;
    if ({ifb.INTR_ACK, ifb.BUSY, ifb.I_FLG, ifa.PROTO_ERR} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset got %b exp %b",
        {ifb.INTR_ACK, ifb.BUSY, ifb.I_FLG, ifa.PROTO_ERR}, 4'b0000);
    end
    ifb.INTR = 1'b0;
    #1 RST_N = 1'b1;
    tick();
    n_run++;
    if ({strb_b, ifb.INTR_ACK, ifb.BUSY, ifb.I_FLG} !== 9'b0) begin
      n_fail++; $display("FAIL post_reset got %b exp %b",
        {strb_b, ifb.INTR_ACK, ifb.BUSY, ifb.I_FLG}, 9'b0);
    end
  endtask

  initial begin
    test_reset();
    test_ld_cz();
    test_interrupt();
    test_retie();
    test_same_cycle();
    test_proto_err();
    test_ack4_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
